scramble_engine: RTL and testbench



---
 rtl/scramble_pkg.sv | 22 ++
 rtl/scramble_lfsr.sv | 31 +++
 rtl/scramble_engine.sv | 107 ++++++++++
 tb/tb_scramble_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/scramble_pkg.sv
// Shared types and constants for the puzzle scramble engine and its LFSR.
package scramble_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StDone
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Up/down and left/right differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// 16-bit Galois LFSR (right-shifting) with seed parameter; exposes the two low state bits.
module scramble_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] rnd
);
  import scramble_pkg::*;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/scramble_engine.sv
// Scramble responder: on a request edge emits NUM_MOVES random moves over valid/ready.
// Optional undo filter enabled by defining SCRAMBLE_NO_UNDO_EN.
module scramble_engine #(
  parameter int unsigned NUM_MOVES = 31,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       random_please,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       mix_state,
  output logic       done,
  output logic [7:0] moves_left
);
  import scramble_pkg::*;

  localparam logic [7:0] NumMoves = 8'(NUM_MOVES);

  state_e     state_q;
  logic       req_q, armed_q, pulse_q;
  logic       valid_q, mix_q, done_q;
  logic [1:0] dir_q, rnd, next_dir;
  logic [7:0] left_q;
  logic       accept;

  scramble_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .rnd  (rnd)
  );

  assign accept = valid_q & move_ready;

  // Only used for follow-on moves; the first move of a burst is always the raw draw.
  always_comb begin
    next_dir = rnd;
`ifdef SCRAMBLE_NO_UNDO_EN
    if (rnd == opposite(dir_q)) begin
      next_dir = rnd ^ 2'b10;
    end
`endif
  end

  // armed_q blocks a request level that is already high when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      mix_q   <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 2'd0;
      left_q  <= 8'd0;
    end else begin
      req_q   <= random_please;
      armed_q <= armed_q | ~random_please;
      pulse_q <= random_please & ~req_q & armed_q;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pulse_q) begin
            state_q <= StEmit;
            valid_q <= 1'b1;
            mix_q   <= 1'b1;
            dir_q   <= rnd;
            left_q  <= NumMoves;
          end
        end
        StEmit: begin
          if (accept) begin
            if (left_q == 8'd1) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              mix_q   <= 1'b0;
              done_q  <= 1'b1;
              dir_q   <= 2'd0;
              left_q  <= 8'd0;
            end else begin
              left_q <= left_q - 8'd1;
              dir_q  <= next_dir;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign mix_state  = mix_q;
  assign done       = done_q;
  assign moves_left = left_q;

endmodule

// File: tb/tb_scramble_engine.sv
// Self-checking bench for scramble_engine: scenario table, hand sequences, random bursts.
module tb_scramble_engine;
  localparam int          NUM  = 31;
  localparam logic [7:0]  NUM8 = 8'(NUM);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
`ifdef SCRAMBLE_NO_UNDO_EN
  localparam bit UNDO = 1'b1;
`else
  localparam bit UNDO = 1'b0;
`endif
  localparam int NB = UNDO ? 1000 : 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       random_please = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid, mix_state, done;
  logic [1:0] move_dir;
  logic [7:0] moves_left;

  scramble_engine #(
    .NUM_MOVES(NUM),
    .LFSR_SEED(SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .random_please(random_please),
    .move_ready   (move_ready),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .mix_state    (mix_state),
    .done         (done),
    .moves_left   (moves_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int accepts = 0;
  int dones = 0;
  int last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [1:0] draw(input logic [1:0] raw, input logic [1:0] prev);
    if (UNDO && raw == (prev ^ 2'b01)) return raw ^ 2'b10;
    return raw;
  endfunction

  // Reference model: what each output should be in the current cycle.
  logic [15:0] m_lfsr = SEED;
  bit          m_prev = 1'b0, m_armed = 1'b0;
  bit          m_valid = 1'b0, m_mix = 1'b0, m_done = 1'b0;
  logic [1:0]  m_dir = 2'd0;
  logic [7:0]  m_left = 8'd0;
  int          m_pulse_cyc = -1;
  logic [1:0]  last_acc_dir = 2'd0;

  always @(negedge clk) begin : monitor
    bit         nv, nm, nd;
    logic [1:0] ndir;
    logic [7:0] nl;
    logic [12:0] act, exp;
    if (!rst_n) begin
      m_lfsr = SEED; m_prev = 0; m_armed = 0; m_pulse_cyc = -1;
      m_valid = 0; m_mix = 0; m_done = 0; m_dir = 2'd0; m_left = 8'd0;
    end else begin
      act = {move_valid, mix_state, done, move_dir, moves_left};
      exp = {m_valid, m_mix, m_done, m_dir, m_left};
      check("cycle_outputs", act === exp, act, exp);
      if (move_valid && move_ready) begin
`ifdef SCRAMBLE_NO_UNDO_EN
        if (moves_left != NUM8)
          check("undo_opposite", move_dir != (last_acc_dir ^ 2'b01), move_dir, m_dir);
`endif
        last_acc_dir = move_dir;
        accepts++;
      end
      if (done) begin
        dones++;
        last_done_cyc = cyc;
      end
      nv = m_valid; nm = m_mix; nd = 1'b0; ndir = m_dir; nl = m_left;
      if (m_valid && move_ready) begin
        if (m_left == 8'd1) begin
          nv = 0; nm = 0; nd = 1; ndir = 2'd0; nl = 8'd0;
        end else begin
          nl = m_left - 8'd1;
          ndir = draw(m_lfsr[1:0], m_dir);
        end
      end else if (!m_valid && !m_done && m_pulse_cyc == cyc) begin
        nv = 1; nm = 1; nl = NUM8; ndir = m_lfsr[1:0];
      end
      if (random_please && !m_prev && m_armed) m_pulse_cyc = cyc + 1;
      if (!random_please) m_armed = 1;
      m_prev = random_please;
      m_valid = nv; m_mix = nm; m_done = nd; m_dir = ndir; m_left = nl;
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  typedef struct {
    int hold;       // cycles the request stays high from cycle N
    int extra;      // cycle of an extra one-cycle request, -1 for none
    int stall_at;   // stall start, relative to first emitted move
    int stall_len;
    int exp_acc;
    int exp_dones;
    int exp_lat;    // request cycle to done cycle
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, output int lat, output int acc, output int dn);
    int a0, d0, n;
    a0 = accepts; d0 = dones; n = cyc;
    for (int t = 0; t < 300; t++) begin
      random_please = (t < v.hold) || (v.extra >= 0 && t == v.extra);
      move_ready = !(v.stall_len > 0 && t >= 2 + v.stall_at && t < 2 + v.stall_at + v.stall_len);
      step();
    end
    lat = last_done_cyc - n;
    acc = accepts - a0;
    dn = dones - d0;
  endtask

  vec_t vecs[6];

  initial begin
    int lat, acc, dn, a0, d0, t;
    vecs[0] = '{hold: 1,   extra: -1, stall_at: 0,  stall_len: 0, exp_acc: 31, exp_dones: 1, exp_lat: 33};
    vecs[1] = '{hold: 1,   extra: -1, stall_at: 10, stall_len: 5, exp_acc: 31, exp_dones: 1, exp_lat: 38};
    vecs[2] = '{hold: 1,   extra: 15, stall_at: 0,  stall_len: 0, exp_acc: 31, exp_dones: 1, exp_lat: 33};
    vecs[3] = '{hold: 100, extra: -1, stall_at: 0,  stall_len: 0, exp_acc: 31, exp_dones: 1, exp_lat: 33};
    vecs[4] = '{hold: 1,   extra: 32, stall_at: 0,  stall_len: 0, exp_acc: 31, exp_dones: 1, exp_lat: 33};
    vecs[5] = '{hold: 1,   extra: -1, stall_at: 0,  stall_len: 3, exp_acc: 31, exp_dones: 1, exp_lat: 36};

    // Reset with the request already high: nothing may start.
    random_please = 1'b1;
    move_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_outputs", {move_valid, mix_state, done, move_dir, moves_left} == 13'd0,
          {move_valid, mix_state, done, move_dir, moves_left}, 0);
    move_ready = 1'b1;
    repeat (10) step();
    check("held_at_reset_accepts", accepts == 0, accepts, 0);
    check("held_at_reset_dones", dones == 0, dones, 0);
    random_please = 1'b0;
    repeat (3) step();

    foreach (vecs[i]) begin
      run_vec(vecs[i], lat, acc, dn);
      check($sformatf("vec%0d_accepts", i), acc == vecs[i].exp_acc, acc, vecs[i].exp_acc);
      check($sformatf("vec%0d_dones", i), dn == vecs[i].exp_dones, dn, vecs[i].exp_dones);
      check($sformatf("vec%0d_done_latency", i), lat == vecs[i].exp_lat, lat, vecs[i].exp_lat);
    end

    // Mid-burst reset after 10 accepts.
    a0 = accepts; d0 = dones;
    move_ready = 1'b1;
    random_please = 1'b1;
    step();
    random_please = 1'b0;
    t = 0;
    while (accepts - a0 < 10 && t < 60) begin
      step();
      t++;
    end
    check("midreset_reach_10", accepts - a0 >= 10, accepts - a0, 10);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {move_valid, mix_state, done, move_dir, moves_left} == 13'd0,
          {move_valid, mix_state, done, move_dir, moves_left}, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (50) step();
    check("midreset_no_done", dones == d0, dones - d0, 0);

    // Random back-pressure bursts.
    for (int b = 0; b < NB; b++) begin
      a0 = accepts; d0 = dones;
      random_please = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        move_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      random_please = 1'b0;
      t = 0;
      while (dones == d0 && t < 400) begin
        move_ready = ($urandom_range(0, 3) != 0);
        step();
        t++;
      end
      check("rand_burst_done", dones == d0 + 1, dones - d0, 1);
      check("rand_burst_accepts", accepts - a0 == NUM, accepts - a0, NUM);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
